// File: rtl/vx_lane_serializer.sv
// vx_lane_serializer
// Takes one multi-lane packet per input handshake and emits it as a stream of
// single-lane beats, one per active lane of the packet mask, lowest lane first.
// A packet whose last beat is leaving can be replaced in the same cycle, so
// consecutive packets stream with no idle cycle between them.

module vx_lane_serializer #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32,
    localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            valid_in,
    output logic                            ready_in,
    input  logic [NUM_LANES-1:0]            mask_in,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [LANE_BITS-1:0]            lane_out,
    output logic                            last_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]                      state;
    logic [NUM_LANES*DATA_WIDTH-1:0] pkt_data;
    logic [NUM_LANES-1:0]            rem_mask;

    logic [NUM_LANES-1:0]            pfx;
    logic [NUM_LANES-1:0]            sel_onehot;
    logic [LANE_BITS-1:0]            sel_lane;
    logic [DATA_WIDTH-1:0]           sel_data;

    logic                            beat_xfer;
    logic                            last_xfer;
    logic                            pkt_accept;
    logic                            pkt_nonzero;

    // Inclusive low-to-high OR scan of the lanes still waiting to be sent.
    always_comb begin
        logic acc;
        acc = 1'b0;
        pfx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            acc    = acc | rem_mask[i];
            pfx[i] = acc;
        end
    end

    // The first set bit of the scan is the lowest pending lane.
    assign sel_onehot = pfx & ~(pfx << 1);

    // Encode the one-hot select into a lane index and mux that lane's data.
    always_comb begin
        sel_lane = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel_onehot[i]) begin
                sel_lane = sel_lane | LANE_BITS'(i);
                sel_data = sel_data | pkt_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign valid_out = (state == BUSY);
    assign data_out  = sel_data;
    assign lane_out  = sel_lane;
    assign last_out  = valid_out && ((rem_mask & ~sel_onehot) == '0);

    assign beat_xfer   = valid_out && ready_out;
    assign last_xfer   = beat_xfer && last_out;

    // Refill is allowed while idle or in the very cycle the last beat leaves;
    // nothing is accepted while reset is being asserted.
    assign ready_in    = reset_n && ((state == IDLE) || last_xfer);
    assign pkt_accept  = valid_in && ready_in;
    assign pkt_nonzero = (mask_in != '0);

    // Packet capture, per-beat lane retirement and the IDLE/BUSY sequencing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            rem_mask <= '0;
        end else if (pkt_accept) begin
            if (pkt_nonzero) begin
                pkt_data <= data_in;
                rem_mask <= mask_in;
                state    <= BUSY;
            end else begin
                rem_mask <= '0;
                state    <= IDLE;
            end
        end else if (last_xfer) begin
            rem_mask <= '0;
            state    <= IDLE;
        end else if (beat_xfer) begin
            rem_mask <= rem_mask & ~sel_onehot;
        end
    end

endmodule

// File: tb/tb_vx_lane_serializer.sv
// tb_vx_lane_serializer
// Directed bench for the 4-lane, 32-bit serializer: reset, single packet,
// backpressure hold, back-to-back packets, zero-mask drop and mid-packet reset.

module tb_vx_lane_serializer;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int LB = 2;

    logic              clk;
    logic              reset_n;
    logic              valid_in;
    logic              ready_in;
    logic [NL-1:0]     mask_in;
    logic [NL*DW-1:0]  data_in;
    logic              valid_out;
    logic              ready_out;
    logic [DW-1:0]     data_out;
    logic [LB-1:0]     lane_out;
    logic              last_out;

    int n_checks;
    int n_fails;

    vx_lane_serializer #(.NUM_LANES(NL), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .mask_in   (mask_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .lane_out  (lane_out),
        .last_out  (last_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NL*DW-1:0] pack4(input logic [DW-1:0] d3, input logic [DW-1:0] d2,
                                               input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [NL-1:0] m, input logic [NL*DW-1:0] d);
        valid_in = v;
        mask_in  = m;
        data_in  = d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBeat(input string tag, input logic [DW-1:0] d, input logic [LB-1:0] l,
                             input logic last, input logic rdy);
        checkOutput({tag, ".valid"}, 32'(valid_out), 32'd1);
        checkOutput({tag, ".data"},  data_out, d);
        checkOutput({tag, ".lane"},  32'(lane_out), 32'(l));
        checkOutput({tag, ".last"},  32'(last_out), 32'(last));
        checkOutput({tag, ".ready_in"}, 32'(ready_in), 32'(rdy));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".valid"}, 32'(valid_out), 32'd0);
        checkOutput({tag, ".ready_in"}, 32'(ready_in), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset_n   = 1'b0;
        ready_out = 1'b1;
        valid_in  = 1'b0;
        mask_in   = '0;
        data_in   = '0;

        // Reset
        tick();
        tick();
        checkOutput("reset.valid", 32'(valid_out), 32'd0);
        checkOutput("reset.ready_in", 32'(ready_in), 32'd0);
        reset_n = 1'b1;
        tick();
        checkIdle("post_reset");

        // Single packet, mask 1011
        applyStimulus(1'b1, 4'b1011, pack4(32'h44, 32'h33, 32'h22, 32'h11));
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkBeat("p1.b0", 32'h11, 2'd0, 1'b0, 1'b0);
        tick();
        checkBeat("p1.b1", 32'h22, 2'd1, 1'b0, 1'b0);
        tick();
        checkBeat("p1.b2", 32'h44, 2'd3, 1'b1, 1'b1);
        tick();
        checkIdle("p1.end");

        // Same packet with backpressure on the 2nd beat for 3 cycles
        applyStimulus(1'b1, 4'b1011, pack4(32'h44, 32'h33, 32'h22, 32'h11));
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkBeat("bp.b0", 32'h11, 2'd0, 1'b0, 1'b0);
        tick();
        ready_out = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkBeat("bp.hold", 32'h22, 2'd1, 1'b0, 1'b0);
            tick();
        end
        ready_out = 1'b1;
        #1;
        checkBeat("bp.b1", 32'h22, 2'd1, 1'b0, 1'b0);
        tick();
        checkBeat("bp.b2", 32'h44, 2'd3, 1'b1, 1'b1);
        tick();
        checkIdle("bp.end");

        // Back-to-back: 1111 then 0100 offered continuously
        applyStimulus(1'b1, 4'b1111, pack4(32'hA3, 32'hA2, 32'hA1, 32'hA0));
        tick();
        applyStimulus(1'b1, 4'b0100, pack4(32'hB3, 32'hB2, 32'hB1, 32'hB0));
        checkBeat("b2b.b0", 32'hA0, 2'd0, 1'b0, 1'b0);
        tick();
        checkBeat("b2b.b1", 32'hA1, 2'd1, 1'b0, 1'b0);
        tick();
        checkBeat("b2b.b2", 32'hA2, 2'd2, 1'b0, 1'b0);
        tick();
        checkBeat("b2b.b3", 32'hA3, 2'd3, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkBeat("b2b.b4", 32'hB2, 2'd2, 1'b1, 1'b1);
        tick();
        checkIdle("b2b.end");

        // Zero-mask packet in IDLE is dropped
        applyStimulus(1'b1, 4'b0000, pack4(32'h99, 32'h99, 32'h99, 32'h99));
        checkOutput("zero.ready_in", 32'(ready_in), 32'd1);
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkIdle("zero.after");
        tick();
        checkIdle("zero.after2");
        applyStimulus(1'b1, 4'b1000, pack4(32'hC3, 32'hC2, 32'hC1, 32'hC0));
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkBeat("zero.next", 32'hC3, 2'd3, 1'b1, 1'b1);
        tick();
        checkIdle("zero.end");

        // Zero-mask packet arriving on the last beat returns to IDLE
        applyStimulus(1'b1, 4'b0011, pack4(32'hD3, 32'hD2, 32'hD1, 32'hD0));
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkBeat("zl.b0", 32'hD0, 2'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b0000, '0);
        checkBeat("zl.b1", 32'hD1, 2'd1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkIdle("zl.end");

        // Reset during the 2nd beat of a 4-lane packet
        applyStimulus(1'b1, 4'b1111, pack4(32'hE3, 32'hE2, 32'hE1, 32'hE0));
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkBeat("rst.b0", 32'hE0, 2'd0, 1'b0, 1'b0);
        tick();
        checkBeat("rst.b1", 32'hE1, 2'd1, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("rst.ready_low", 32'(ready_in), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        checkOutput("rst.valid", 32'(valid_out), 32'd0);
        tick();
        checkIdle("rst.recover");
        tick();
        checkOutput("rst.no_beats", 32'(valid_out), 32'd0);
        applyStimulus(1'b1, 4'b0110, pack4(32'hF3, 32'hF2, 32'hF1, 32'hF0));
        tick();
        applyStimulus(1'b0, 4'b0000, '0);
        checkBeat("rst.p.b0", 32'hF1, 2'd1, 1'b0, 1'b0);
        tick();
        checkBeat("rst.p.b1", 32'hF2, 2'd2, 1'b1, 1'b1);
        tick();
        checkIdle("rst.p.end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
